// File: rtl/floppy_timer_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : floppy_timer_sched_pkg
//  Description : Shared constants for the floppy timer scheduler: register
//                map, channel count, constant register values and the scan
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package floppy_timer_sched_pkg;

  localparam int NCHAN = 4;

  // Register map
  localparam logic [3:0] ADDR_CNT0   = 4'd0;
  localparam logic [3:0] ADDR_CNT1   = 4'd1;
  localparam logic [3:0] ADDR_CNT2   = 4'd2;
  localparam logic [3:0] ADDR_CNT3   = 4'd3;
  localparam logic [3:0] ADDR_STATUS = 4'd4;
  localparam logic [3:0] ADDR_MASK   = 4'd5;
  localparam logic [3:0] ADDR_CTRL   = 4'd6;
  localparam logic [3:0] ADDR_ID     = 4'd7;
  localparam logic [3:0] ADDR_RLD0   = 4'd8;

  localparam logic [7:0] ID_VALUE   = 8'hA5;
  // All four channels enabled, RUN set
  localparam logic [7:0] CTRL_RESET = 8'hF1;

  // Scan sequencer: one state per channel, visited in order after each tick
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN0 = 3'd1,
    ST_SCAN1 = 3'd2,
    ST_SCAN2 = 3'd3,
    ST_SCAN3 = 3'd4
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/floppy_timer_sched_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : floppy_tick_prescaler
//  Description : Free-running down counter that divides the master clock to
//                the scheduler tick. Emits a one-cycle registered pulse each
//                time the counter passes through zero.
//  Revision    : 1.0 - initial release
//  Ports       : clk   - master clock
//                reset - asynchronous active-high reset
//                tick  - one-cycle pulse every TICKDIV clocks
// ============================================================================
module floppy_tick_prescaler #(
  parameter int TICKDIV = 240000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  // 18 bits covers the 100 Hz divider at 24 MHz; widen only when needed
  localparam int             CW     = ((TICKDIV - 1) < (1 << 18)) ? 18 : 24;
  localparam logic [CW-1:0]  RELOAD = CW'(TICKDIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= RELOAD;
      r_tick <= 1'b0;
    end else if (r_cnt == '0) begin
      r_cnt  <= RELOAD;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt - CW'(1);
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/floppy_timer_sched.sv
`default_nettype none
// ============================================================================
//  Module      : floppy_timer_sched
//  Description : Four-channel 8-bit software timer scheduler. A shared
//                prescaler produces the tick; a scan sequencer walks the
//                channels one per cycle through a single decrementer.
//                Expiry flags are masked onto one level interrupt.
//  Revision    : 1.0 - initial release
//  Options     : FLOPPY_TIMER_AUTORELOAD_EN - adds RLD0-RLD3 at 8-11; an
//                expiring channel reloads from its RLD register.
//  Ports       : clk   - master clock
//                reset - asynchronous active-high reset
//                addr  - register address
//                di    - write data
//                wren  - write strobe (one cycle per access)
//                rden  - read strobe (one cycle per access)
//                q     - registered read data, valid the cycle after rden
//                irq   - level interrupt, |(flags & mask)
//                tick  - prescaler tick pulse (debug)
// ============================================================================
module floppy_timer_sched
  import floppy_timer_sched_pkg::*;
#(
  parameter int MCLKFREQ = 24000000,
  parameter int TICKDIV  = MCLKFREQ / 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] addr,
  input  logic [7:0] di,
  input  logic       wren,
  input  logic       rden,
  output logic [7:0] q,
  output logic       irq,
  output logic       tick
);

  scan_state_t      r_state;
  logic [7:0]       r_cnt [NCHAN];
  logic [NCHAN-1:0] r_flags;
  logic [NCHAN-1:0] r_mask;
  logic [NCHAN-1:0] r_en;
  logic             r_run;
  logic [7:0]       r_q;

  logic             w_tick;
  logic [NCHAN-1:0] w_scan_sel;
  logic [NCHAN-1:0] w_cnt_wr;
  logic [NCHAN-1:0] w_dec;
  logic [NCHAN-1:0] w_expire;
  logic             w_status_rd;
  logic [7:0]       w_reload [NCHAN];
  logic [7:0]       w_rdata;

  floppy_tick_prescaler #(
    .TICKDIV (TICKDIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

`ifdef FLOPPY_TIMER_AUTORELOAD_EN
  logic [7:0] r_rld [NCHAN];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NCHAN; n++) r_rld[n] <= 8'd0;
    end else if (wren && (addr[3:2] == ADDR_RLD0[3:2])) begin
      r_rld[addr[1:0]] <= di;
    end
  end
`endif

  always_comb begin
    w_scan_sel = '0;
    case (r_state)
      ST_SCAN0: w_scan_sel[0] = 1'b1;
      ST_SCAN1: w_scan_sel[1] = 1'b1;
      ST_SCAN2: w_scan_sel[2] = 1'b1;
      ST_SCAN3: w_scan_sel[3] = 1'b1;
      default:  w_scan_sel    = '0;
    endcase

    w_cnt_wr = '0;
    if (wren && (addr[3:2] == ADDR_CNT0[3:2])) w_cnt_wr[addr[1:0]] = 1'b1;

    // A host write to the channel being scanned takes priority over the
    // decrement, so the new value is never immediately consumed or flagged.
    for (int n = 0; n < NCHAN; n++) begin
      w_dec[n]    = w_scan_sel[n] && r_en[n] && (r_cnt[n] != 8'd0) && !w_cnt_wr[n];
      w_expire[n] = w_dec[n] && (r_cnt[n] == 8'd1);
`ifdef FLOPPY_TIMER_AUTORELOAD_EN
      w_reload[n] = r_rld[n];
`else
      w_reload[n] = 8'd0;
`endif
    end

    w_status_rd = rden && (addr == ADDR_STATUS);
  end

  always_comb begin
    w_rdata = 8'd0;
    case (addr)
      ADDR_CNT0, ADDR_CNT1, ADDR_CNT2, ADDR_CNT3: w_rdata = r_cnt[addr[1:0]];
      ADDR_STATUS: w_rdata = {4'b0000, r_flags};
      ADDR_MASK:   w_rdata = {4'b0000, r_mask};
      ADDR_CTRL:   w_rdata = {r_en, 3'b000, r_run};
      ADDR_ID:     w_rdata = ID_VALUE;
`ifdef FLOPPY_TIMER_AUTORELOAD_EN
      ADDR_RLD0, ADDR_RLD0 + 4'd1, ADDR_RLD0 + 4'd2, ADDR_RLD0 + 4'd3:
        w_rdata = r_rld[addr[1:0]];
`else
      ADDR_RLD0, ADDR_RLD0 + 4'd1, ADDR_RLD0 + 4'd2, ADDR_RLD0 + 4'd3:
        w_rdata = 8'd0;
`endif
      default:     w_rdata = 8'd0;
    endcase
  end

  // Scan sequencer: a tick while RUN is clear is simply dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_tick && r_run) r_state <= ST_SCAN0;
        ST_SCAN0: r_state <= ST_SCAN1;
        ST_SCAN1: r_state <= ST_SCAN2;
        ST_SCAN2: r_state <= ST_SCAN3;
        ST_SCAN3: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NCHAN; n++) r_cnt[n] <= 8'd0;
      r_flags <= '0;
      r_mask  <= '0;
      r_en    <= CTRL_RESET[7:4];
      r_run   <= CTRL_RESET[0];
      r_q     <= 8'd0;
    end else begin
      for (int n = 0; n < NCHAN; n++) begin
        if (w_cnt_wr[n])       r_cnt[n] <= di;
        else if (w_expire[n])  r_cnt[n] <= w_reload[n];
        else if (w_dec[n])     r_cnt[n] <= r_cnt[n] - 8'd1;
      end
      // A fresh expiry survives a clearing STATUS read in the same cycle
      r_flags <= (w_status_rd ? '0 : r_flags) | w_expire;
      if (wren && (addr == ADDR_MASK)) r_mask <= di[NCHAN-1:0];
      if (wren && (addr == ADDR_CTRL)) begin
        r_run <= di[0];
        r_en  <= di[7:4];
      end
      if (rden) r_q <= w_rdata;
    end
  end

  assign q    = r_q;
  assign irq  = |(r_flags & r_mask);
  assign tick = w_tick;

endmodule
`default_nettype wire
